// File: rtl/pixel_normalizer.sv
// Normalizes a cropped pixel frame to full OUT_BIT_WIDTH range using a reciprocal scale
// computed by an iterative divider. Optional round-half-up in stage 2: PIXEL_NORM_ROUND_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// ST_IDLE     | ap_ready high, waiting for ap_start
// ST_WAIT_MAX | waiting for cf_ap_done; latches max_value when it arrives
// ST_DIVIDE   | restoring divide, one scale bit per cycle, MSB first
// ST_STREAM   | accepting N pixels and emitting N scaled beats
// ST_DONE     | one-cycle ap_done pulse, then back to idle

module pixel_normalizer #(
    parameter int PIXEL_BIT_WIDTH = 10,
    parameter int OUT_BIT_WIDTH   = 8,
    parameter int OUT_ROWS        = 10,
    parameter int OUT_COLS        = 10,
    parameter int FRAC_BITS       = 16
) (
    input  logic                       clk,
    input  logic                       s_axis_resetn,
    input  logic                       ap_start,
    output logic                       ap_ready,
    output logic                       ap_done,
    input  logic                       cf_ap_done,
    input  logic [PIXEL_BIT_WIDTH-1:0] max_value,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [OUT_BIT_WIDTH-1:0]   m_axis_tdata,
    output logic                       m_axis_tlast
);

    localparam int N         = OUT_ROWS * OUT_COLS;
    localparam int CNT_W     = $clog2(N + 1);
    localparam int SCALE_W   = OUT_BIT_WIDTH + FRAC_BITS;
    localparam int PROD_W    = PIXEL_BIT_WIDTH + SCALE_W;
    localparam int DIV_CNT_W = $clog2(SCALE_W);

    localparam logic [CNT_W-1:0]     N_C      = CNT_W'(N);
    localparam logic [CNT_W-1:0]     LAST_C   = CNT_W'(N - 1);
    localparam logic [DIV_CNT_W-1:0] DIV_TOP  = DIV_CNT_W'(SCALE_W - 1);
    localparam logic [SCALE_W-1:0]   DIVIDEND = {{OUT_BIT_WIDTH{1'b1}}, {FRAC_BITS{1'b0}}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_MAX,
        ST_DIVIDE,
        ST_STREAM,
        ST_DONE
    } state_t;

    state_t                     r_state;
    logic                       r_ap_ready;
    logic                       r_ap_done;
    logic [PIXEL_BIT_WIDTH-1:0] r_max;
    logic [SCALE_W-1:0]         r_scale;
    logic [PIXEL_BIT_WIDTH-1:0] r_rem;
    logic [DIV_CNT_W-1:0]       r_div_cnt;
    logic [CNT_W-1:0]           r_in_cnt;
    logic [CNT_W-1:0]           r_out_cnt;

    logic                       r_s1_valid;
    logic                       r_s1_last;
    logic [PROD_W-1:0]          r_prod;
    logic                       r_m_valid;
    logic                       r_m_last;
    logic [OUT_BIT_WIDTH-1:0]   r_m_data;

    logic [SCALE_W-1:0]         w_dividend;
    logic [PIXEL_BIT_WIDTH:0]   w_rem_shift;
    logic [PIXEL_BIT_WIDTH:0]   w_rem_diff;
    logic                       w_rem_ge;
    logic                       w_advance;
    logic                       w_in_fire;
    logic                       w_out_fire;
    logic [PROD_W-1:0]          w_prod;
    logic [PROD_W:0]            w_sum;
    logic [PROD_W:0]            w_shift;
    logic [OUT_BIT_WIDTH-1:0]   w_sat;

    // Remainder stays below max, so the borrow out of the subtract is the compare result.
    assign w_dividend  = DIVIDEND;
    assign w_rem_shift = {r_rem, w_dividend[r_div_cnt]};
    assign w_rem_diff  = w_rem_shift - {1'b0, r_max};
    assign w_rem_ge    = ~w_rem_diff[PIXEL_BIT_WIDTH];

    assign w_advance     = m_axis_tready | ~r_m_valid;
    assign s_axis_tready = (r_state == ST_STREAM) && w_advance && (r_in_cnt < N_C);
    assign w_in_fire     = s_axis_tready & s_axis_tvalid;
    assign w_out_fire    = r_m_valid & m_axis_tready;

    assign w_prod = PROD_W'(s_axis_tdata) * PROD_W'(r_scale);

`ifdef PIXEL_NORM_ROUND_EN
    localparam logic [PROD_W:0] ROUND_HALF = (PROD_W + 1)'(1) << (FRAC_BITS - 1);
    assign w_sum = {1'b0, r_prod} + ROUND_HALF;
`else
    assign w_sum = {1'b0, r_prod};
`endif

    assign w_shift = w_sum >> FRAC_BITS;
    assign w_sat   = (|w_shift[PROD_W:OUT_BIT_WIDTH]) ? {OUT_BIT_WIDTH{1'b1}}
                                                      : w_shift[OUT_BIT_WIDTH-1:0];

    assign ap_ready      = r_ap_ready;
    assign ap_done       = r_ap_done;
    assign m_axis_tvalid = r_m_valid;
    assign m_axis_tdata  = r_m_data;
    assign m_axis_tlast  = r_m_last;

    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            r_state    <= ST_IDLE;
            r_ap_ready <= 1'b1;
            r_ap_done  <= 1'b0;
            r_max      <= '0;
            r_scale    <= '0;
            r_rem      <= '0;
            r_div_cnt  <= '0;
            r_in_cnt   <= '0;
            r_out_cnt  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_state    <= ST_WAIT_MAX;
                        r_ap_ready <= 1'b0;
                    end
                end
                ST_WAIT_MAX: begin
                    if (cf_ap_done) begin
                        r_max     <= max_value;
                        r_scale   <= '0;
                        r_rem     <= '0;
                        r_div_cnt <= DIV_TOP;
                        // A zero max would divide by zero; stream with a zero scale instead.
                        r_state   <= (max_value == '0) ? ST_STREAM : ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    r_rem   <= w_rem_ge ? w_rem_diff[PIXEL_BIT_WIDTH-1:0]
                                        : w_rem_shift[PIXEL_BIT_WIDTH-1:0];
                    r_scale <= {r_scale[SCALE_W-2:0], w_rem_ge};
                    if (r_div_cnt == '0) begin
                        r_state <= ST_STREAM;
                    end else begin
                        r_div_cnt <= r_div_cnt - 1'b1;
                    end
                end
                ST_STREAM: begin
                    if (w_in_fire) begin
                        r_in_cnt <= r_in_cnt + 1'b1;
                    end
                    if (w_out_fire) begin
                        if (r_out_cnt == LAST_C) begin
                            r_out_cnt <= '0;
                            r_in_cnt  <= '0;
                            r_ap_done <= 1'b1;
                            r_state   <= ST_DONE;
                        end else begin
                            r_out_cnt <= r_out_cnt + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_ap_done  <= 1'b0;
                    r_ap_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ap_ready <= 1'b1;
                    r_ap_done  <= 1'b0;
                end
            endcase
        end
    end

    // Both stages move as one; a stalled output freezes the multiplier stage too.
    always_ff @(posedge clk) begin
        if (!s_axis_resetn) begin
            r_s1_valid <= 1'b0;
            r_s1_last  <= 1'b0;
            r_prod     <= '0;
            r_m_valid  <= 1'b0;
            r_m_last   <= 1'b0;
            r_m_data   <= '0;
        end else if (w_advance) begin
            r_s1_valid <= w_in_fire;
            r_s1_last  <= w_in_fire && (r_in_cnt == LAST_C);
            if (w_in_fire) begin
                r_prod <= w_prod;
            end
            r_m_valid <= r_s1_valid;
            r_m_last  <= r_s1_valid & r_s1_last;
            if (r_s1_valid) begin
                r_m_data <= w_sat;
            end
        end
    end

endmodule

// File: tb/tb_pixel_normalizer.sv
// Scoreboard bench for pixel_normalizer: directed frames push expected beats into a queue,
// a negedge monitor pops and compares every output handshake.

module tb_pixel_normalizer;

    localparam int PW = 10;
    localparam int OW = 8;
    localparam int N  = 100;

    logic          clk           = 1'b0;
    logic          s_axis_resetn = 1'b0;
    logic          ap_start      = 1'b0;
    logic          ap_ready;
    logic          ap_done;
    logic          cf_ap_done    = 1'b0;
    logic [PW-1:0] max_value     = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [PW-1:0] s_axis_tdata  = '0;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic [OW-1:0] m_axis_tdata;
    logic          m_axis_tlast;

    pixel_normalizer dut (
        .clk           (clk),
        .s_axis_resetn (s_axis_resetn),
        .ap_start      (ap_start),
        .ap_ready      (ap_ready),
        .ap_done       (ap_done),
        .cf_ap_done    (cf_ap_done),
        .max_value     (max_value),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int beats    = 0;
    int accepts  = 0;
    int dones    = 0;
    int lasts    = 0;

    logic [PW-1:0] pix  [N];
    logic [OW-1:0] expv [N];
    logic [OW:0]   sb_q [$];

    logic          hold_v    = 1'b0;
    logic          hold_last = 1'b0;
    logic [OW-1:0] hold_data = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference scaling with a hand-derived scale constant.
    function automatic logic [OW-1:0] norm(input int p, input longint scale);
        longint prod;
        prod = longint'(p) * scale;
`ifdef PIXEL_NORM_ROUND_EN
        prod = prod + 32768;
`endif
        prod = prod >>> 16;
        if (prod > 255) return 8'hFF;
        return OW'(prod);
    endfunction

    always @(negedge clk) begin
        logic [OW:0] e;
        if (!s_axis_resetn) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                chk("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                    {1'b1, hold_last, hold_data});
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat actual=%0d required=none", m_axis_tdata);
                end else begin
                    e = sb_q.pop_front();
                    chk("beat_data", m_axis_tdata, e[OW-1:0]);
                    chk("beat_last", m_axis_tlast, e[OW]);
                end
                beats++;
                if (m_axis_tlast) lasts++;
            end
            hold_v    = m_axis_tvalid && !m_axis_tready;
            hold_last = m_axis_tlast;
            hold_data = m_axis_tdata;
            if (s_axis_tvalid && s_axis_tready) accepts++;
            if (ap_done) dones++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input int maxv, input bit rnd, input bit poke, input int abort_beat);
        int  b0, a0, d0, l0, idx, wait_cnt, stalls;
        bit  early, acc, got_done;
        b0 = beats; a0 = accepts; d0 = dones; l0 = lasts;
        idx = 0; stalls = 0; early = 0; got_done = 0;
        for (int i = 0; i < N; i++) sb_q.push_back({(i == N - 1), expv[i]});

        chk("ready_idle", ap_ready, 1);
        ap_start = 1'b1;
        step();
        ap_start      = 1'b0;
        m_axis_tready = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = pix[0];
        repeat (3) begin
            @(negedge clk);
            if (s_axis_tready) early = 1;
        end
        chk("tready_before_max", early, 0);
        step();
        max_value  = PW'(maxv);
        cf_ap_done = 1'b1;
        step();
        cf_ap_done = 1'b0;
        max_value  = '0;
        wait_cnt   = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (s_axis_tready) break;
            wait_cnt++;
        end
        chk("divide_cycles", wait_cnt, (maxv == 0) ? 0 : 24);

        for (int it = 0; it < 5000; it++) begin
            if (ap_done) begin
                got_done = 1;
                break;
            end
            acc = s_axis_tvalid && s_axis_tready;
            if (!rnd && idx > 0 && idx < N && !acc) stalls++;
            step();
            if (acc) idx++;
            s_axis_tvalid = (idx < N);
            s_axis_tdata  = (idx < N) ? pix[idx] : '0;
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ap_start      = poke && (beats - b0 == 50);
            cf_ap_done    = poke && (beats - b0 == 50);
            max_value     = (poke && (beats - b0 == 50)) ? PW'(7) : '0;
            if (abort_beat >= 0 && beats - b0 >= abort_beat) begin
                s_axis_resetn = 1'b0;
                s_axis_tvalid = 1'b0;
                m_axis_tready = 1'b1;
                ap_start      = 1'b0;
                cf_ap_done    = 1'b0;
                @(posedge clk);
                @(negedge clk);
                chk("rst_ap_ready", ap_ready, 1);
                chk("rst_ap_done", ap_done, 0);
                chk("rst_s_tready", s_axis_tready, 0);
                chk("rst_m_tvalid", m_axis_tvalid, 0);
                chk("rst_m_tlast", m_axis_tlast, 0);
                chk("rst_m_tdata", m_axis_tdata, 0);
                sb_q.delete();
                step();
                s_axis_resetn = 1'b1;
                step();
                return;
            end
            @(negedge clk);
        end
        chk("done_seen", got_done, 1);
        step();
        s_axis_tvalid = 1'b0;
        ap_start      = 1'b0;
        cf_ap_done    = 1'b0;
        chk("frame_beats", beats - b0, N);
        chk("frame_accepts", accepts - a0, N);
        chk("frame_dones", dones - d0, 1);
        chk("frame_tlasts", lasts - l0, 1);
        chk("queue_empty", sb_q.size(), 0);
        if (!rnd) chk("full_rate_stalls", stalls, 0);
        @(negedge clk);
        chk("done_one_cycle", {ap_done, ap_ready}, 2'b01);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) step();
        @(negedge clk);
        chk("reset_ap_ready", ap_ready, 1);
        chk("reset_ap_done", ap_done, 0);
        chk("reset_s_tready", s_axis_tready, 0);
        chk("reset_m_tvalid", m_axis_tvalid, 0);
        chk("reset_m_tlast", m_axis_tlast, 0);
        chk("reset_m_tdata", m_axis_tdata, 0);
        step();
        s_axis_resetn = 1'b1;
        step();

        // max 1000: hand values for 1000, 500, 0; remainder a ramp
        for (int i = 0; i < N; i++) begin
            pix[i]  = PW'(i * 10);
            expv[i] = norm(i * 10, 16711);
        end
        pix[0] = 10'd1000; pix[1] = 10'd500; pix[2] = 10'd0;
`ifdef PIXEL_NORM_ROUND_EN
        expv[0] = 8'd255;
`else
        expv[0] = 8'd254;
`endif
        expv[1] = 8'd127; expv[2] = 8'd0;
        run_frame(1000, 0, 0, -1);

        // max 1: pixel 1 -> 255, pixel 2 saturates
        for (int i = 0; i < N; i++) begin
            pix[i]  = PW'(i % 3);
            expv[i] = (i % 3 == 0) ? 8'd0 : 8'd255;
        end
        run_frame(1, 0, 0, -1);

        // max 0: everything zero, no divide phase
        for (int i = 0; i < N; i++) begin
            pix[i]  = PW'(i * 10);
            expv[i] = 8'd0;
        end
        run_frame(0, 0, 0, -1);

        // ramp with random downstream backpressure and stray start/done pulses
        for (int i = 0; i < N; i++) begin
            pix[i]  = PW'(i * 10);
            expv[i] = norm(i * 10, 16711);
        end
        run_frame(1000, 1, 1, -1);

        // reset at beat 40, then a clean frame
        run_frame(1000, 1, 0, 40);
        run_frame(1000, 0, 0, -1);

        // back-to-back frames with different max values
        run_frame(1000, 1, 0, -1);
        for (int i = 0; i < N; i++) begin
            pix[i]  = PW'(i * 2);
            expv[i] = OW'(i * 2);
        end
        pix[N-1]  = 10'd1023;
        expv[N-1] = 8'd255;
        run_frame(255, 0, 0, -1);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
